// File: rtl/layer_xfer_seq.sv
// layer_xfer_seq: sequences one inter-layer hand-off in the CNN pipeline.
// It waits for the source layer's output, copies every (channel,row,col) of the
// source outmem into the destination inmem, then launches the destination
// compute and waits for that layer to finish.
// Optional feature: define LAYER_XFER_SEQ_FLAT_EN to add the wr_flat output,
// which carries the flattened destination index alongside wr_en.
module layer_xfer_seq #(
  parameter int NUM_CH   = 16,
  parameter int DIM      = 13,
  parameter int READ_LAT = 1,
  parameter int IDX_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             src_done,
  output logic [IDX_W-1:0] rd_ch,
  output logic [IDX_W-1:0] rd_row,
  output logic [IDX_W-1:0] rd_col,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_ch,
  output logic [IDX_W-1:0] wr_row,
  output logic [IDX_W-1:0] wr_col,
`ifdef LAYER_XFER_SEQ_FLAT_EN
  output logic [IDX_W-1:0] wr_flat,
`endif
  output logic             dst_start,
  input  logic             dst_done,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SRC,
    COPY,
    DRAIN,
    LAUNCH,
    WAIT_DST,
    FIN
  } state_t;

  localparam longint unsigned IdxRange = 64'd1 << IDX_W;
  localparam logic [IDX_W-1:0] LastCh  = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DIM - 1);
  localparam logic [2:0]       LastDrain = 3'(READ_LAT - 1);

  // Reject parameter sets the counters and the delay pipe cannot represent.
  generate
    if (READ_LAT < 1 || READ_LAT > 4) begin : gBadReadLat
      $error("layer_xfer_seq: READ_LAT must be in 1..4");
    end
    if (64'(NUM_CH) >= IdxRange || 64'(DIM) >= IdxRange) begin : gBadIdxW
      $error("layer_xfer_seq: NUM_CH and DIM must each be < 2**IDX_W");
    end
`ifdef LAYER_XFER_SEQ_FLAT_EN
    if (64'(NUM_CH) * 64'(DIM) * 64'(DIM) > IdxRange) begin : gBadFlatW
      $error("layer_xfer_seq: NUM_CH*DIM*DIM must be <= 2**IDX_W");
    end
`endif
  endgenerate

  state_t           state_q;
  logic [IDX_W-1:0] chCnt_q, rowCnt_q, colCnt_q;
  logic [IDX_W-1:0] chCnt_d, rowCnt_d, colCnt_d;
  logic             lastIssue;
  logic [2:0]       drainCnt_q;
  logic             dstDonePrev_q;
  logic             dstStart_q;
  logic             done_q;

  logic [READ_LAT-1:0] pipeVld_q;
  logic [IDX_W-1:0]    pipeCh_q  [READ_LAT];
  logic [IDX_W-1:0]    pipeRow_q [READ_LAT];
  logic [IDX_W-1:0]    pipeCol_q [READ_LAT];

  // Raster-order successor of the read counter; col is fastest, channel slowest.
  always_comb begin
    chCnt_d   = chCnt_q;
    rowCnt_d  = rowCnt_q;
    colCnt_d  = colCnt_q;
    lastIssue = (chCnt_q == LastCh) && (rowCnt_q == LastIdx) && (colCnt_q == LastIdx);
    if (colCnt_q == LastIdx) begin
      colCnt_d = '0;
      if (rowCnt_q == LastIdx) begin
        rowCnt_d = '0;
        chCnt_d  = chCnt_q + 1'b1;
      end else begin
        rowCnt_d = rowCnt_q + 1'b1;
      end
    end else begin
      colCnt_d = colCnt_q + 1'b1;
    end
  end

  // Main hand-off FSM; the counter freezes on the final read so rd_* holds it afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      chCnt_q    <= '0;
      rowCnt_q   <= '0;
      colCnt_q   <= '0;
      drainCnt_q <= '0;
      dstStart_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      dstStart_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) state_q <= WAIT_SRC;
        end
        WAIT_SRC: begin
          if (src_done) begin
            state_q  <= COPY;
            chCnt_q  <= '0;
            rowCnt_q <= '0;
            colCnt_q <= '0;
          end
        end
        COPY: begin
          if (lastIssue) begin
            state_q    <= DRAIN;
            drainCnt_q <= '0;
          end else begin
            chCnt_q  <= chCnt_d;
            rowCnt_q <= rowCnt_d;
            colCnt_q <= colCnt_d;
          end
        end
        DRAIN: begin
          if (drainCnt_q == LastDrain) begin
            state_q    <= LAUNCH;
            dstStart_q <= 1'b1;
          end else begin
            drainCnt_q <= drainCnt_q + 3'd1;
          end
        end
        LAUNCH: begin
          state_q <= WAIT_DST;
        end
        WAIT_DST: begin
          if (dst_done && !dstDonePrev_q) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // History of dst_done so that only a fresh rising edge can end the wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      dstDonePrev_q <= 1'b0;
    end else begin
      dstDonePrev_q <= dst_done;
    end
  end

  // Delay line matching the outmem read latency; data stages only load on valid so wr_* hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipeVld_q <= '0;
      for (int s = 0; s < READ_LAT; s++) begin
        pipeCh_q[s]  <= '0;
        pipeRow_q[s] <= '0;
        pipeCol_q[s] <= '0;
      end
    end else begin
      pipeVld_q[0] <= (state_q == COPY);
      if (state_q == COPY) begin
        pipeCh_q[0]  <= chCnt_q;
        pipeRow_q[0] <= rowCnt_q;
        pipeCol_q[0] <= colCnt_q;
      end
      for (int s = 1; s < READ_LAT; s++) begin
        pipeVld_q[s] <= pipeVld_q[s-1];
        if (pipeVld_q[s-1]) begin
          pipeCh_q[s]  <= pipeCh_q[s-1];
          pipeRow_q[s] <= pipeRow_q[s-1];
          pipeCol_q[s] <= pipeCol_q[s-1];
        end
      end
    end
  end

`ifdef LAYER_XFER_SEQ_FLAT_EN
  logic [IDX_W-1:0] flat_q;

  // Flattened write index kept as a running count to avoid any multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      flat_q <= '0;
    end else if (state_q == WAIT_SRC && src_done) begin
      flat_q <= '0;
    end else if (pipeVld_q[READ_LAT-1]) begin
      flat_q <= flat_q + 1'b1;
    end
  end

  assign wr_flat = flat_q;
`endif

  assign rd_ch     = chCnt_q;
  assign rd_row    = rowCnt_q;
  assign rd_col    = colCnt_q;
  assign wr_en     = pipeVld_q[READ_LAT-1];
  assign wr_ch     = pipeCh_q[READ_LAT-1];
  assign wr_row    = pipeRow_q[READ_LAT-1];
  assign wr_col    = pipeCol_q[READ_LAT-1];
  assign dst_start = dstStart_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_layer_xfer_seq.sv
// Testbench for layer_xfer_seq: two instances (READ_LAT=1 and READ_LAT=3) share
// the control inputs; each scenario task watches the instance it targets.
// Expected write tuples are queued when a run is launched and popped on wr_en.
module tb_layer_xfer_seq;

  localparam int NCH   = 2;
  localparam int D     = 3;
  localparam int IW    = 16;
  localparam int TOTAL = NCH * D * D;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic srcDone = 1'b0;
  logic dstDone = 1'b0;

  logic [IW-1:0] rdCh1, rdRow1, rdCol1, wrCh1, wrRow1, wrCol1;
  logic          wrEn1, dstStart1, busy1, done1;
  logic [IW-1:0] rdCh3, rdRow3, rdCol3, wrCh3, wrRow3, wrCol3;
  logic          wrEn3, dstStart3, busy3, done3;
`ifdef LAYER_XFER_SEQ_FLAT_EN
  logic [IW-1:0] wrFlat1, wrFlat3;
`endif

  typedef struct packed {
    logic [IW-1:0] ch;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic [IW-1:0] flat;
  } wr_t;

  wr_t q1[$];
  wr_t q3[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  layer_xfer_seq #(.NUM_CH(NCH), .DIM(D), .READ_LAT(1), .IDX_W(IW)) dut1 (
    .clk(clk), .reset(reset), .start(start), .src_done(srcDone),
    .rd_ch(rdCh1), .rd_row(rdRow1), .rd_col(rdCol1),
    .wr_en(wrEn1), .wr_ch(wrCh1), .wr_row(wrRow1), .wr_col(wrCol1),
`ifdef LAYER_XFER_SEQ_FLAT_EN
    .wr_flat(wrFlat1),
`endif
    .dst_start(dstStart1), .dst_done(dstDone), .busy(busy1), .done(done1)
  );

  layer_xfer_seq #(.NUM_CH(NCH), .DIM(D), .READ_LAT(3), .IDX_W(IW)) dut3 (
    .clk(clk), .reset(reset), .start(start), .src_done(srcDone),
    .rd_ch(rdCh3), .rd_row(rdRow3), .rd_col(rdCol3),
    .wr_en(wrEn3), .wr_ch(wrCh3), .wr_row(wrRow3), .wr_col(wrCol3),
`ifdef LAYER_XFER_SEQ_FLAT_EN
    .wr_flat(wrFlat3),
`endif
    .dst_start(dstStart3), .dst_done(dstDone), .busy(busy3), .done(done3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference raster order: col fastest, then row, then channel.
  function automatic wr_t expEntry(int k);
    wr_t e;
    e.ch  = IW'(k / (D * D));
    e.row = IW'((k / D) % D);
    e.col = IW'(k % D);
`ifdef LAYER_XFER_SEQ_FLAT_EN
    e.flat = IW'(k);
`else
    e.flat = '0;
`endif
    return e;
  endfunction

  function automatic wr_t act1();
    wr_t a;
    a.ch = wrCh1; a.row = wrRow1; a.col = wrCol1;
`ifdef LAYER_XFER_SEQ_FLAT_EN
    a.flat = wrFlat1;
`else
    a.flat = '0;
`endif
    return a;
  endfunction

  function automatic wr_t act3();
    wr_t a;
    a.ch = wrCh3; a.row = wrRow3; a.col = wrCol3;
`ifdef LAYER_XFER_SEQ_FLAT_EN
    a.flat = wrFlat3;
`else
    a.flat = '0;
`endif
    return a;
  endfunction

  task automatic doReset();
    reset = 1'b1; start = 1'b0; srcDone = 1'b0; dstDone = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Launch a run: start then src_done, leaving both instances in their first COPY cycle.
  task automatic startRun();
    start = 1'b1;
    tick();
    start = 1'b0;
    srcDone = 1'b1;
    tick();
    srcDone = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    doReset();
    checks++;
    if ({busy1, wrEn1, done1, dstStart1, busy3, wrEn3, done3, dstStart3} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b required 00000000",
               {busy1, wrEn1, done1, dstStart1, busy3, wrEn3, done3, dstStart3});
    end
    checks++;
    if ({rdCh1, rdRow1, rdCol1, wrCh1, wrRow1, wrCol1} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_idx1: got rd %0d,%0d,%0d wr %0d,%0d,%0d required all 0",
               rdCh1, rdRow1, rdCol1, wrCh1, wrRow1, wrCol1);
    end
    checks++;
    if ({rdCh3, rdRow3, rdCol3, wrCh3, wrRow3, wrCol3} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_idx3: got rd %0d,%0d,%0d wr %0d,%0d,%0d required all 0",
               rdCh3, rdRow3, rdCol3, wrCh3, wrRow3, wrCol3);
    end
  endtask

  task automatic test_basic_copy();
    int  wrCount = 0, firstWr = -1, lastWr = -1, dstCycle = -1, dstPulses = 0;
    wr_t e;
    $display("[TB] test_basic_copy");
    doReset();
    q1.delete();
    for (int k = 0; k < TOTAL; k++) q1.push_back(expEntry(k));
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_start: got %b required 1", busy1);
    end
    tick();
    srcDone = 1'b1;
    tick();
    srcDone = 1'b0;
    for (int k = 0; k < TOTAL + 4; k++) begin
      if (k < TOTAL) begin
        e = expEntry(k);
        checks++;
        if ({rdCh1, rdRow1, rdCol1} !== {e.ch, e.row, e.col}) begin
          errors++;
          $display("[TB] FAIL rd_order k=%0d: got %0d,%0d,%0d required %0d,%0d,%0d",
                   k, rdCh1, rdRow1, rdCol1, e.ch, e.row, e.col);
        end
      end
      if (wrEn1) begin
        wrCount++;
        if (firstWr < 0) firstWr = k;
        lastWr = k;
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("[TB] FAIL wr_extra1 k=%0d: got a write required none", k);
        end else begin
          e = q1.pop_front();
          if (act1() !== e) begin
            errors++;
            $display("[TB] FAIL wr_seq1 k=%0d: got %h required %h", k, act1(), e);
          end
        end
      end
      if (dstStart1) begin
        dstPulses++;
        dstCycle = k;
      end
      tick();
    end
    checks++;
    if (firstWr != 1 || lastWr != TOTAL || wrCount != TOTAL) begin
      errors++;
      $display("[TB] FAIL wr_window1: got first %0d last %0d count %0d required 1 %0d %0d",
               firstWr, lastWr, wrCount, TOTAL, TOTAL);
    end
    checks++;
    if (dstPulses != 1 || dstCycle != TOTAL + 1) begin
      errors++;
      $display("[TB] FAIL dst_start1: got %0d pulses at %0d required 1 at %0d",
               dstPulses, dstCycle, TOTAL + 1);
    end
    checks++;
    if ({rdCh1, rdRow1, rdCol1, wrCh1, wrRow1, wrCol1, wrEn1} !== {IW'(1), IW'(2), IW'(2), IW'(1), IW'(2), IW'(2), 1'b0}) begin
      errors++;
      $display("[TB] FAIL idx_hold1: got rd %0d,%0d,%0d wr %0d,%0d,%0d en %b required 1,2,2 1,2,2 0",
               rdCh1, rdRow1, rdCol1, wrCh1, wrRow1, wrCol1, wrEn1);
    end
    dstDone = 1'b1;
    tick();
    checks++;
    if (done1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_pulse1: got %b required 1", done1);
    end
    dstDone = 1'b0;
    tick();
    checks++;
    if ({done1, busy1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL back_idle1: got done %b busy %b required 0 0", done1, busy1);
    end
  endtask

  task automatic test_dst_edge();
    bit found = 1'b0;
    $display("[TB] test_dst_edge");
    doReset();
    dstDone = 1'b1;
    startRun();
    for (int i = 0; i < 40 && !found; i++) begin
      if (dstStart1) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL dst_start_wait: got no dst_start within 40 cycles required one");
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy1, done1} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL held_high_wait %0d: got busy %b done %b required 1 0", i, busy1, done1);
      end
      tick();
    end
    dstDone = 1'b0;
    tick();
    checks++;
    if ({busy1, done1} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL low_wait: got busy %b done %b required 1 0", busy1, done1);
    end
    dstDone = 1'b1;
    tick();
    checks++;
    if (done1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL edge_done: got %b required 1", done1);
    end
    start = 1'b1;
    tick();
    checks++;
    if ({busy1, done1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL start_in_fin: got busy %b done %b required 0 0", busy1, done1);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_after_fin: got busy %b required 1", busy1);
    end
    dstDone = 1'b0;
  endtask

  task automatic test_read_lat3();
    int  wrCount = 0, firstWr = -1, lastWr = -1, dstCycle = -1, dstPulses = 0;
    wr_t e;
    $display("[TB] test_read_lat3");
    doReset();
    q3.delete();
    for (int k = 0; k < TOTAL; k++) q3.push_back(expEntry(k));
    startRun();
    for (int k = 0; k < TOTAL + 6; k++) begin
      if (wrEn3) begin
        wrCount++;
        if (firstWr < 0) firstWr = k;
        lastWr = k;
        checks++;
        if (q3.size() == 0) begin
          errors++;
          $display("[TB] FAIL wr_extra3 k=%0d: got a write required none", k);
        end else begin
          e = q3.pop_front();
          if (act3() !== e) begin
            errors++;
            $display("[TB] FAIL wr_seq3 k=%0d: got %h required %h", k, act3(), e);
          end
        end
      end
      if (dstStart3) begin
        dstPulses++;
        dstCycle = k;
      end
      tick();
    end
    checks++;
    if (firstWr != 3 || lastWr != TOTAL + 2 || wrCount != TOTAL) begin
      errors++;
      $display("[TB] FAIL wr_window3: got first %0d last %0d count %0d required 3 %0d %0d",
               firstWr, lastWr, wrCount, TOTAL + 2, TOTAL);
    end
    checks++;
    if (dstPulses != 1 || dstCycle != TOTAL + 3) begin
      errors++;
      $display("[TB] FAIL dst_start3: got %0d pulses at %0d required 1 at %0d",
               dstPulses, dstCycle, TOTAL + 3);
    end
    dstDone = 1'b1;
    tick();
    checks++;
    if (done3 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_pulse3: got %b required 1", done3);
    end
    dstDone = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    int  wrCount = 0, dstCycle = -1;
    wr_t e;
    $display("[TB] test_reset_abort");
    doReset();
    q1.delete();
    for (int k = 0; k < TOTAL; k++) q1.push_back(expEntry(k));
    startRun();
    for (int k = 0; k < 20; k++) begin
      if (wrEn1) begin
        wrCount++;
        checks++;
        e = q1.pop_front();
        if (act1() !== e) begin
          errors++;
          $display("[TB] FAIL abort_seq k=%0d: got %h required %h", k, act1(), e);
        end
      end
      if (wrCount == 5) break;
      tick();
    end
    checks++;
    if (wrCount != 5) begin
      errors++;
      $display("[TB] FAIL abort_reach: got %0d writes required 5", wrCount);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({wrEn1, busy1, dstStart1} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_state: got wr_en %b busy %b dst_start %b required 0 0 0",
               wrEn1, busy1, dstStart1);
    end
    tick();
    checks++;
    if ({wrEn1, busy1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got wr_en %b busy %b required 0 0", wrEn1, busy1);
    end
    // Fresh run after the abort, with a stray start pulse in the middle of COPY.
    q1.delete();
    for (int k = 0; k < TOTAL; k++) q1.push_back(expEntry(k));
    wrCount = 0;
    startRun();
    for (int k = 0; k < TOTAL + 4; k++) begin
      start = (k == 7);
      if (wrEn1) begin
        wrCount++;
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("[TB] FAIL rerun_extra k=%0d: got a write required none", k);
        end else begin
          e = q1.pop_front();
          if (act1() !== e) begin
            errors++;
            $display("[TB] FAIL rerun_seq k=%0d: got %h required %h", k, act1(), e);
          end
        end
      end
      if (dstStart1) dstCycle = k;
      tick();
    end
    start = 1'b0;
    checks++;
    if (wrCount != TOTAL || dstCycle != TOTAL + 1) begin
      errors++;
      $display("[TB] FAIL rerun_count: got %0d writes dst at %0d required %0d at %0d",
               wrCount, dstCycle, TOTAL, TOTAL + 1);
    end
    dstDone = 1'b1;
    tick();
    dstDone = 1'b0;
    checks++;
    if (done1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rerun_done: got %b required 1", done1);
    end
    tick();
    tick();
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_not_queued: got busy %b required 0", busy1);
    end
  endtask

  // Scenario sequence followed by the one summary line.
  initial begin
    test_reset();
    test_basic_copy();
    test_dst_edge();
    test_read_lat3();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net in case the scenario sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion required finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
